// File: rtl/gate_tt_checker_pkg.sv
// gate_tt_pkg: shared definitions for the gate truth-table checker.
//   state_t  - sequencer state encoding (IDLE, DRIVE, SAMPLE, DONE)
//   TT_NAND  - default expected truth table for a 2-input Nand
package gate_tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_tt_checker_if.sv
// gate_tt_checker_if: signal bundle between a checker and its controller/DUT side.
//   start      - begin a run (controller -> checker)
//   dut_out    - gate under test output (DUT -> checker)
//   stim       - vector driven into the gate under test
//   busy/done  - run status
//   pass       - run finished with no mismatches
//   err_count  - mismatching vectors in the current or last run
//   fail_valid - a mismatch has been seen this run
//   fail_vec   - index of the first mismatching vector
// Modports: master = controller/DUT side, slave = checker.
interface gate_tt_checker_if #(
  parameter int N_IN = 2
);

  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            fail_valid;
  logic [N_IN-1:0] fail_vec;

  modport master (
    output start, dut_out,
    input  stim, busy, done, pass, err_count, fail_valid, fail_vec
  );

  modport slave (
    input  start, dut_out,
    output stim, busy, done, pass, err_count, fail_valid, fail_vec
  );

endinterface

// File: rtl/gate_tt_checker_settle_timer.sv
// settle_timer: counts the cycles a vector has been held on the gate inputs.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   clear        - force the count back to zero
//   enable       - advance the count by one
//   expired      - count has reached SETTLE-1 (vector has settled)
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] count;

  // The count saturates at LAST; the sequencer leaves DRIVE on that cycle anyway.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: walks every input vector through a combinational gate,
// waits SETTLE cycles per vector, samples the gate output and compares it
// with the EXPECT truth table. Counts mismatches and latches the first one.
//   clock, reset - rising-edge clock, synchronous active-high reset
//   bus (slave)  - start/dut_out in; stim, busy, done, pass, err_count,
//                  fail_valid, fail_vec out
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int                      N_IN   = 2,
  parameter int                      SETTLE = 1,
  parameter logic [(2**N_IN)-1:0]    EXPECT = TT_NAND
) (
  input  logic               clock,
  input  logic               reset,
  gate_tt_checker_if.slave   bus
);

  localparam logic [N_IN-1:0] LAST_IDX = '1;

  state_t          state, state_n;
  logic [N_IN-1:0] idx;
  logic [N_IN:0]   err_count;
  logic            fail_valid;
  logic [N_IN-1:0] fail_vec;
  logic            expired;
  logic            accept;
  logic            mismatch;
  logic            last_vec;

  // A new run may only be accepted while no run is in progress.
  assign accept   = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_vec = (idx == LAST_IDX);
  assign mismatch = (bus.dut_out != EXPECT[idx]);

  // Held at zero outside DRIVE so each vector starts a fresh settle interval.
  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clock   (clock),
    .reset   (reset),
    .clear   (state != ST_DRIVE),
    .enable  (state == ST_DRIVE),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: if (bus.start) state_n = ST_DRIVE;
      ST_DRIVE:         if (expired)   state_n = ST_SAMPLE;
      ST_SAMPLE:        state_n = last_vec ? ST_DONE : ST_DRIVE;
      default:          state_n = ST_IDLE;
    endcase
  end

  // Vector index and result registers; idx stays on the last vector in DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (accept) begin
      idx        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (state == ST_SAMPLE) begin
      if (mismatch) begin
        err_count <= err_count + 1'b1;
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_vec   <= idx;
        end
      end
      if (!last_vec) begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.stim       = idx;
  assign bus.busy       = (state == ST_DRIVE) || (state == ST_SAMPLE);
  assign bus.done       = (state == ST_DONE);
  assign bus.pass       = (state == ST_DONE) && (err_count == '0);
  assign bus.err_count  = err_count;
  assign bus.fail_valid = fail_valid;
  assign bus.fail_vec   = fail_vec;

endmodule
